fsk_zc_demod: RTL and testbench

FSK_ZC_DEMOD -- requirements
Module: fsk_zc_demod

---
 rtl/fsk_demod_pkg.sv | 14 +
 rtl/fsk_period_counter.sv | 45 ++++
 rtl/fsk_zc_demod.sv | 159 +++++++++++++++
 tb/tb_fsk_zc_demod.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_demod_pkg.sv
// Shared types and default sizing for the zero-crossing FSK demodulator.
package fsk_demod_pkg;

  localparam int CNT_W_DEF   = 9;
  localparam int SYM_LEN_DEF = 100;
  localparam int VOTE_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2
  } state_e;

endpackage

// File: rtl/fsk_period_counter.sv
// IF sign register, rising-edge detector and saturating cycles-since-edge counter.
module fsk_period_counter
  import fsk_demod_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             if_sign_i,
  output logic             rise_o,
  output logic [CNT_W-1:0] pcnt_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] PMAX = {CNT_W{1'b1}};

  logic             sign_q;
  logic [CNT_W-1:0] pcnt_q;
  logic [CNT_W-1:0] pcnt_d;

  assign rise_o = en_i & if_sign_i & ~sign_q;
  assign sat_o  = (pcnt_q == PMAX);
  assign pcnt_o = pcnt_q;

  always_comb begin
    pcnt_d = pcnt_q;
    if (rise_o) begin
      pcnt_d = '0;
    end else if (!sat_o) begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      pcnt_q <= '0;
    end else begin
      sign_q <= if_sign_i;
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/fsk_zc_demod.sv
// Zero-crossing FSK demodulator: measures IF period between rising edges and
// majority-votes the per-period tone decisions over each symbol window.
module fsk_zc_demod
  import fsk_demod_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int SYM_LEN = SYM_LEN_DEF,
  parameter int VOTE_W  = VOTE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             if_sign,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] period,
  output logic             edge_valid,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             no_signal
);

  localparam int SCNT_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SYM_LEN - 1);
  localparam logic [CNT_W-1:0]  PMAX      = {CNT_W{1'b1}};
  localparam logic [VOTE_W-1:0] VMAX      = {VOTE_W{1'b1}};

  logic             rise;
  logic             sat;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] period_meas;
  logic             timeout;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              edge_valid_q, edge_valid_d;
  logic              bit_out_q, bit_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              no_signal_q, no_signal_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [VOTE_W-1:0] ones_q, ones_d;
  logic [VOTE_W-1:0] zeros_q, zeros_d;

  fsk_period_counter #(
    .CNT_W(CNT_W)
  ) u_pcnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en),
    .if_sign_i(if_sign),
    .rise_o   (rise),
    .pcnt_o   (pcnt),
    .sat_o    (sat)
  );

  // pcnt holds (cycles since edge - 1), so the edge-to-edge distance is pcnt+1
  assign period_meas = sat ? PMAX : pcnt + 1'b1;
  assign timeout     = sat & ~rise;

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    edge_valid_d = 1'b0;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    no_signal_d  = no_signal_q & ~rise;
    scnt_d       = scnt_q;
    ones_d       = ones_q;
    zeros_d      = zeros_q;

    unique case (state_q)
      ST_IDLE: begin
        scnt_d  = '0;
        ones_d  = '0;
        zeros_d = '0;
        state_d = ST_ACQ;
      end
      ST_ACQ: begin
        scnt_d  = '0;
        ones_d  = '0;
        zeros_d = '0;
        if (rise) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (timeout) begin
          state_d     = ST_ACQ;
          no_signal_d = 1'b1;
          scnt_d      = '0;
          ones_d      = '0;
          zeros_d     = '0;
        end else begin
          if (rise) begin
            period_d     = period_meas;
            edge_valid_d = 1'b1;
            if (period_meas < thresh) begin
              if (ones_q != VMAX) ones_d = ones_q + 1'b1;
            end else begin
              if (zeros_q != VMAX) zeros_d = zeros_q + 1'b1;
            end
          end
          // Window close sees the vote cast in this same cycle
          if (scnt_q == SCNT_LAST) begin
            scnt_d      = '0;
            bit_valid_d = 1'b1;
            if (ones_d > zeros_d)      bit_out_d = 1'b1;
            else if (zeros_d > ones_d) bit_out_d = 1'b0;
            ones_d  = '0;
            zeros_d = '0;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!en) begin
      state_d      = ST_IDLE;
      period_d     = period_q;
      edge_valid_d = 1'b0;
      bit_out_d    = bit_out_q;
      bit_valid_d  = 1'b0;
      no_signal_d  = no_signal_q;
      scnt_d       = '0;
      ones_d       = '0;
      zeros_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      period_q     <= '0;
      edge_valid_q <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      no_signal_q  <= 1'b0;
      scnt_q       <= '0;
      ones_q       <= '0;
      zeros_q      <= '0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      edge_valid_q <= edge_valid_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      no_signal_q  <= no_signal_d;
      scnt_q       <= scnt_d;
      ones_q       <= ones_d;
      zeros_q      <= zeros_d;
    end
  end

  assign period     = period_q;
  assign edge_valid = edge_valid_q;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign no_signal  = no_signal_q;

endmodule

// File: tb/tb_fsk_zc_demod.sv
// Bench for fsk_zc_demod: directed square waves plus random IF, checked every
// cycle against a timestamp-based reference model.
module tb_fsk_zc_demod;
  import fsk_demod_pkg::*;

  localparam int CNT_W   = 9;
  localparam int SYM_LEN = 100;
  localparam int VOTE_W  = 4;
  localparam int PMAX    = (1 << CNT_W) - 1;
  localparam int VMAX    = (1 << VOTE_W) - 1;

  logic             clk = 1'b0;
  logic             rst, en, if_sign;
  logic [CNT_W-1:0] thresh;
  logic [CNT_W-1:0] period;
  logic             edge_valid, bit_out, bit_valid, no_signal;

  always #5 clk = ~clk;

  fsk_zc_demod #(
    .CNT_W  (CNT_W),
    .SYM_LEN(SYM_LEN),
    .VOTE_W (VOTE_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .if_sign   (if_sign),
    .thresh    (thresh),
    .period    (period),
    .edge_valid(edge_valid),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .no_signal (no_signal)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int phase  = 0;

  // reference model state: times of last counter clear and window start
  state_e m_state   = ST_IDLE;
  int     last_ref  = 0;
  int     win_start = 0;
  bit     m_prev    = 1'b0;
  bit     votes[$];
  int     e_period  = 0;
  bit     e_ev = 1'b0, e_bo = 1'b0, e_bv = 1'b0, e_ns = 1'b0;
  int     obs_bv = 0, exp_bv = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
  endtask

  task automatic model_step();
    bit rise;
    bit timed_out;
    int age, per, n1, n0;
    e_ev = 1'b0;
    e_bv = 1'b0;
    if (rst) begin
      m_state  = ST_IDLE;
      e_period = 0;
      e_bo     = 1'b0;
      e_ns     = 1'b0;
      m_prev   = 1'b0;
      last_ref = cyc;
      votes.delete();
    end else begin
      rise = en && if_sign && !m_prev;
      age  = cyc - last_ref - 1;
      if (age > PMAX) age = PMAX;
      if (rise) e_ns = 1'b0;
      if (!en) begin
        m_state = ST_IDLE;
        votes.delete();
      end else begin
        case (m_state)
          ST_IDLE: m_state = ST_ACQ;
          ST_ACQ: begin
            if (rise) begin
              m_state   = ST_TRACK;
              win_start = cyc + 1;
              votes.delete();
            end
          end
          default: begin
            timed_out = 1'b0;
            if (rise) begin
              per = cyc - last_ref;
              if (per > PMAX) per = PMAX;
              e_period = per;
              e_ev     = 1'b1;
              votes.push_back(per < int'(thresh));
            end else if (age == PMAX) begin
              timed_out = 1'b1;
              m_state   = ST_ACQ;
              e_ns      = 1'b1;
              votes.delete();
            end
            if (!timed_out && ((cyc - win_start) % SYM_LEN) == SYM_LEN - 1) begin
              n1 = 0;
              n0 = 0;
              foreach (votes[i]) if (votes[i]) n1++; else n0++;
              if (n1 > VMAX) n1 = VMAX;
              if (n0 > VMAX) n0 = VMAX;
              if (n1 > n0) e_bo = 1'b1;
              else if (n0 > n1) e_bo = 1'b0;
              e_bv = 1'b1;
              exp_bv++;
              votes.delete();
            end
          end
        endcase
      end
      if (rise) last_ref = cyc;
      m_prev = if_sign;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic s);
    rst     = r;
    en      = e;
    if_sign = s;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    if (bit_valid === 1'b1) obs_bv++;
    chk("period", 32'(period), 32'(e_period));
    chk("edge_valid", 32'(edge_valid), 32'(e_ev));
    chk("bit_out", 32'(bit_out), 32'(e_bo));
    chk("bit_valid", 32'(bit_valid), 32'(e_bv));
    chk("no_signal", 32'(no_signal), 32'(e_ns));
    chk("state", 32'(dut.state_q), 32'(m_state));
  endtask

  task automatic do_reset(input int th);
    thresh = CNT_W'(th);
    phase  = 0;
    repeat (3) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic sq(input int p, input int n, input logic e);
    for (int i = 0; i < n; i++) begin
      step(1'b0, e, (phase % p) < (p / 2));
      phase++;
    end
  endtask

  initial begin
    // 80-cycle tone: high tone, period reported as 80
    do_reset(100);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_bits", 32'({edge_valid, bit_out, bit_valid, no_signal}), 32'd0);
    sq(80, 460, 1'b1);
    chk("s1_period", 32'(period), 32'd80);
    chk("s1_bitout", 32'(bit_out), 32'd1);

    // 133-cycle tone: low tone
    do_reset(100);
    sq(133, 700, 1'b1);
    chk("s2_period", 32'(period), 32'd133);
    chk("s2_bitout", 32'(bit_out), 32'd0);

    // tone stops: timeout back to ACQ with no_signal
    do_reset(100);
    sq(80, 300, 1'b1);
    repeat (600) step(1'b0, 1'b1, 1'b0);
    chk("s3_nosig", 32'(no_signal), 32'd1);
    chk("s3_state", 32'(dut.state_q), 32'(ST_ACQ));

    // 150-cycle tone: windows with zero or one edge
    do_reset(100);
    sq(150, 900, 1'b1);
    chk("s4_period", 32'(period), 32'd150);

    // reset pulse mid-window
    do_reset(100);
    sq(80, 250, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("s5_period", 32'(period), 32'd0);
    sq(80, 350, 1'b1);

    // enable drop mid-window, then reacquire
    do_reset(100);
    sq(80, 250, 1'b1);
    sq(80, 30, 1'b0);
    sq(80, 400, 1'b1);
    chk("s6_period", 32'(period), 32'd80);
    chk("bv_count", 32'(obs_bv), 32'(exp_bv));

    // random IF: mixed tones, short bursts, dropouts, en drops, resets
    do_reset($urandom_range(60, 160));
    begin
      logic lvl;
      int   len;
      int   pick;
      lvl = 1'b0;
      for (int seg = 0; seg < 260; seg++) begin
        pick = $urandom_range(0, 99);
        if (pick < 2) begin
          repeat (600) step(1'b0, 1'b1, 1'b0);
          lvl = 1'b0;
        end else if (pick < 5) begin
          len = $urandom_range(1, 30);
          repeat (len) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end else if (pick < 6) begin
          step(1'b1, 1'b1, 1'b0);
        end else begin
          len = (pick < 25) ? $urandom_range(1, 3) : $urandom_range(20, 110);
          lvl = ~lvl;
          repeat (len) step(1'b0, 1'b1, lvl);
        end
        if (seg % 50 == 49) thresh = CNT_W'($urandom_range(30, 200));
      end
    end
    chk("bv_total", 32'(obs_bv), 32'(exp_bv));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
